sram_sdp_sync: RTL and testbench
================================

# sram_sdp_sync

Simple dual-port synchronous SRAM: one write port and one independent read port sharing one clock, parametrised in depth, word width, byte-lane width and read latency. Adds per-lane write enables, a registered read path with a valid strobe, and a post-reset zero-fill sequencer. It is the general-purpose storage primitive for buffers and register files in the memory subsystem, replacing the single-port asynchronous-read SRAM where concurrent read/write and clean timing are required.

## Interface
- `depth`, default 16: number of words; any value ≥ 2, not required to be a power of two.
- `width`, default 32: word width in bits; must be a multiple of `lane_width`.
- `lane_width`, default 8: bits per write-enable lane; lanes = `width/lane_width`.
- `rd_lat`, default 1: read latency in cycles, legal values 1 or 2.

Address width is AW = `$clog2(depth)`, minimum 1.

- `clk`  in  1: single clock, all logic on rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `we`  in  1: write request.
- `wr_add`  in  AW: write address.
- `data_in`  in  `width`: write data.
- `be`  in  lanes: per-lane write enable; lane i covers bits [i*lane_width +: lane_width].
- `re`  in  1: read request.
- `rd_add`  in  AW: read address.
- `data_out`  out  `width`: read data.
- `rd_valid`  out  1: one-cycle strobe, `data_out` is valid.
- `init_done`  out  1: high once the zero-fill completes; requests are accepted only while high.

## Operation
- FSM has two states, INIT and READY. `rst_n`=0 at an edge forces INIT with fill counter=0.
- INIT: each cycle writes all-zero to word[counter] and increments the counter. After the write to `depth-1` the FSM moves to READY. `we`/`re` are ignored, no `rd_valid` is generated, and `init_done`=0.
- READY: `init_done`=1 and the FSM stays there until reset.
- Write: at an edge with `we`=1 in READY, each lane with `be[i]`=1 takes `data_in` for that lane. Lanes with `be[i]`=0 are unchanged. `we`=1 with `be`=0 is a no-op.
- Read: at an edge with `re`=1 in READY, the word at `rd_add` is captured. After `rd_lat` edges it appears on `data_out` with `rd_valid`=1 for exactly one cycle.
- `data_out` holds its last value when no read completes.
- Out-of-range address (≥ `depth`): the write is dropped. The read completes normally with `data_out`=0 and `rd_valid`=1.
- Back-to-back reads are fully pipelined at one per cycle for both latencies.
- Collision (same-edge `we` and `re`, same in-range address): the result is set by the configuration macro, see Configuration.
- With `rd_lat`=2, a write after the first-stage capture does not alter the in-flight read data.
- Reset mid-operation: in-flight reads are discarded, and `rd_valid`/`data_out` clear at that edge. A new INIT sweep restarts from address 0, including during an active INIT.

## Timing
- Reset values: `data_out`=0, `rd_valid`=0, `init_done`=0.
- `init_done` rises after exactly `depth` edges with `rst_n`=1, counted from the first such edge.
- Read latency: `re` sampled at edge N gives `data_out`/`rd_valid` updated at edge N+`rd_lat`.
- Write latency: data is visible to a read sampled at edge N+1 or later, where N is the write edge.
- Requests at the edge where `init_done` goes 0→1 are ignored. The first accepted request is at the next edge.

## Configuration
- Macro `SRAM_SDP_WR_BYPASS_EN`.
- Defined: on a collision, the read returns the merged word. Lanes with `be[i]`=1 return the new `data_in`, other lanes return the stored value (write-first).
- Undefined: on a collision, the read returns the pre-write stored word (read-first). The write still completes.
- Collisions at different addresses are unaffected in both cases.

## Test plan
- depth=10, width=32, rd_lat=1: release reset, then `re` to addr 3 at the first edge after `init_done` → `init_done` rises 10 edges after release, then `data_out`=0x00000000 with `rd_valid` one edge later.
- Write 0xDEADBEEF to addr 0 with be=4'b1111, then write 0x11223344 with be=4'b0101, then read addr 0 → `data_out`=0xDE22BE44, one-cycle `rd_valid`.
- rd_lat=2, write addr k = k*0x01010101 for k=0..9, then read addrs 0..9 back-to-back → matching words on 10 consecutive cycles starting 2 edges after the first `re`.
- Same-edge write 0xAAAAAAAA be=4'b1111 and read addr 5 (stored 0x05050505) → 0xAAAAAAAA with `SRAM_SDP_WR_BYPASS_EN`, 0x05050505 without. Readback afterwards is 0xAAAAAAAA in both builds.
- Write addr 12 (out of range, depth=10), then read addr 12 → no memory change, `data_out`=0 with `rd_valid`=1.
- Assert `rst_n`=0 for one edge mid-INIT (counter=4) and with a read in flight → `rd_valid`/`data_out` clear, INIT restarts, and `init_done` rises 10 edges after release.

Source files
------------

// File: rtl/sram_sdp_sync.sv
// Simple dual-port synchronous SRAM: per-lane write enables, 1- or 2-cycle registered read, and a post-reset zero-fill.
// Define SRAM_SDP_WR_BYPASS_EN for write-first same-address collisions. The default is read-first.
module sram_sdp_sync #(
  parameter int depth      = 16,
  parameter int width      = 32,
  parameter int lane_width = 8,
  parameter int rd_lat     = 1,
  localparam int AW        = (depth > 1) ? $clog2(depth) : 1,
  localparam int lanes     = width / lane_width
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    wr_add,
  input  logic [width-1:0] data_in,
  input  logic [lanes-1:0] be,
  input  logic             re,
  input  logic [AW-1:0]    rd_add,
  output logic [width-1:0] data_out,
  output logic             rd_valid,
  output logic             init_done
);

  typedef enum logic {INIT, READY} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [width-1:0] mem_q [depth];
  logic [width-1:0] mem_d [depth];
  logic [width-1:0] data_out_q, data_out_d;
  logic             rd_valid_q, rd_valid_d;
  logic             wr_fire, rd_fire;
  logic [width-1:0] rd_word;
  logic             out_valid;
  logic [width-1:0] out_data;

  assign wr_fire = (state_q == READY) && we;
  assign rd_fire = (state_q == READY) && re;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        if (cnt_q == AW'(depth - 1)) begin
          state_d = READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = READY;
    endcase
  end

  // Addresses at or above depth match no word, so out-of-range writes fall through.
  always_comb begin
    mem_d = mem_q;
    if (state_q == INIT) begin
      for (int i = 0; i < depth; i++) begin
        if (cnt_q == AW'(i)) mem_d[i] = '0;
      end
    end else if (wr_fire) begin
      for (int i = 0; i < depth; i++) begin
        if (wr_add == AW'(i)) begin
          for (int j = 0; j < lanes; j++) begin
            if (be[j]) mem_d[i][j*lane_width +: lane_width] = data_in[j*lane_width +: lane_width];
          end
        end
      end
    end
  end

  // Out-of-range reads return zero. With bypass enabled, lanes being written this edge are merged in.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < depth; i++) begin
      if (rd_add == AW'(i)) begin
        rd_word = mem_q[i];
`ifdef SRAM_SDP_WR_BYPASS_EN
        if (wr_fire && (wr_add == rd_add)) begin
          for (int j = 0; j < lanes; j++) begin
            if (be[j]) rd_word[j*lane_width +: lane_width] = data_in[j*lane_width +: lane_width];
          end
        end
`endif
      end
    end
  end

  generate
    if (rd_lat == 2) begin : g_lat2
      logic [width-1:0] s1_data_q, s1_data_d;
      logic             s1_valid_q, s1_valid_d;

      always_comb begin
        s1_valid_d = rd_fire;
        s1_data_d  = rd_fire ? rd_word : s1_data_q;
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          s1_valid_q <= 1'b0;
          s1_data_q  <= '0;
        end else begin
          s1_valid_q <= s1_valid_d;
          s1_data_q  <= s1_data_d;
        end
      end

      assign out_valid = s1_valid_q;
      assign out_data  = s1_data_q;
    end else begin : g_lat1
      assign out_valid = rd_fire;
      assign out_data  = rd_word;
    end
  endgenerate

  always_comb begin
    rd_valid_d = out_valid;
    data_out_d = out_valid ? out_data : data_out_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= INIT;
      cnt_q      <= '0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) mem_q <= mem_d;
  end

  assign data_out  = data_out_q;
  assign rd_valid  = rd_valid_q;
  assign init_done = (state_q == READY);

endmodule

// File: tb/tb_sram_sdp_sync.sv
// Drives shared stimulus into rd_lat=1 and rd_lat=2 instances (depth 10).
// Per-instance monitors check read data and completion cycle against expectation queues.
module tb_sram_sdp_sync;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [3:0]  wr_add;
  logic [31:0] data_in;
  logic [3:0]  be;
  logic        re;
  logic [3:0]  rd_add;
  logic [31:0] data_out1, data_out2;
  logic        rd_valid1, rd_valid2;
  logic        init_done1, init_done2;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t q1[$];
  exp_t q2[$];

  sram_sdp_sync #(.depth(10), .width(32), .lane_width(8), .rd_lat(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .we(we), .wr_add(wr_add), .data_in(data_in), .be(be),
    .re(re), .rd_add(rd_add), .data_out(data_out1), .rd_valid(rd_valid1), .init_done(init_done1)
  );

  sram_sdp_sync #(.depth(10), .width(32), .lane_width(8), .rd_lat(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .we(we), .wr_add(wr_add), .data_in(data_in), .be(be),
    .re(re), .rd_add(rd_add), .data_out(data_out2), .rd_valid(rd_valid2), .init_done(init_done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Each monitor pops when its instance strobes rd_valid and flags overdue or unexpected completions.
  always @(negedge clk) begin
    exp_t e;
    if (rd_valid1) begin
      if (q1.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL lat1_unexpected_valid got data=%h expected no rd_valid (cycle %0d)", data_out1, cyc);
      end else begin
        e = q1.pop_front();
        check_output("lat1_data", data_out1, e.data);
        check_output("lat1_cycle", cyc, e.due);
      end
    end else if (q1.size() != 0 && q1[0].due < cyc) begin
      e = q1.pop_front();
      total++;
      bad++;
      $display("[TB] FAIL lat1_missing_valid got none expected data=%h at cycle %0d", e.data, e.due);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rd_valid2) begin
      if (q2.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL lat2_unexpected_valid got data=%h expected no rd_valid (cycle %0d)", data_out2, cyc);
      end else begin
        e = q2.pop_front();
        check_output("lat2_data", data_out2, e.data);
        check_output("lat2_cycle", cyc, e.due);
      end
    end else if (q2.size() != 0 && q2[0].due < cyc) begin
      e = q2.pop_front();
      total++;
      bad++;
      $display("[TB] FAIL lat2_missing_valid got none expected data=%h at cycle %0d", e.data, e.due);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
    we = 1'b1; wr_add = a; data_in = d; be = b;
    tick();
    we = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a, input logic [31:0] exp, input bit expect_lat2);
    exp_t e;
    re = 1'b1; rd_add = a;
    e.data = exp; e.due = cyc + 1;
    q1.push_back(e);
    if (expect_lat2) begin
      e.due = cyc + 2;
      q2.push_back(e);
    end
    tick();
    re = 1'b0;
  endtask

  task automatic do_collide(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b,
                            input logic [31:0] exp);
    we = 1'b1; wr_add = a; data_in = d; be = b;
    do_read(a, exp, 1'b1);
    we = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_data_out1"}, data_out1, 32'h0);
    check_output({tag, "_rd_valid1"}, {31'b0, rd_valid1}, 32'h0);
    check_output({tag, "_init_done1"}, {31'b0, init_done1}, 32'h0);
    check_output({tag, "_data_out2"}, data_out2, 32'h0);
    check_output({tag, "_rd_valid2"}, {31'b0, rd_valid2}, 32'h0);
    check_output({tag, "_init_done2"}, {31'b0, init_done2}, 32'h0);
  endtask

  // init_done must stay low for nine edges after release and rise on the tenth.
  task automatic run_init();
    for (int k = 1; k <= 10; k++) begin
      tick();
      check_output("init_done1", {31'b0, init_done1}, (k == 10) ? 32'h1 : 32'h0);
      check_output("init_done2", {31'b0, init_done2}, (k == 10) ? 32'h1 : 32'h0);
    end
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; re = 1'b0; wr_add = '0; rd_add = '0; data_in = '0; be = '0;
    idle(2);
    check_reset_outputs("reset");

    re = 1'b1; rd_add = 4'd3; rst_n = 1'b1;
    run_init();
    do_read(4'd3, 32'h0000_0000, 1'b1);
    idle(3);

    do_write(4'd0, 32'hDEAD_BEEF, 4'b1111);
    do_write(4'd0, 32'h1122_3344, 4'b0101);
    do_read(4'd0, 32'hDE22_BE44, 1'b1);
    do_write(4'd1, 32'hFFFF_FFFF, 4'b0000);
    idle(3);

    for (int k = 0; k < 10; k++) do_write(4'(k), 32'h0101_0101 * k, 4'b1111);
    for (int k = 0; k < 10; k++) do_read(4'(k), 32'h0101_0101 * k, 1'b1);
    idle(3);

`ifdef SRAM_SDP_WR_BYPASS_EN
    do_collide(4'd5, 32'hAAAA_AAAA, 4'b1111, 32'hAAAA_AAAA);
    do_collide(4'd6, 32'hBBBB_BBBB, 4'b0011, 32'h0606_BBBB);
`else
    do_collide(4'd5, 32'hAAAA_AAAA, 4'b1111, 32'h0505_0505);
    do_collide(4'd6, 32'hBBBB_BBBB, 4'b0011, 32'h0606_0606);
`endif
    do_read(4'd5, 32'hAAAA_AAAA, 1'b1);
    do_read(4'd6, 32'h0606_BBBB, 1'b1);
    idle(3);

    do_write(4'd12, 32'hFFFF_FFFF, 4'b1111);
    do_read(4'd12, 32'h0000_0000, 1'b1);
    do_read(4'd2, 32'h0202_0202, 1'b1);
    do_read(4'd4, 32'h0404_0404, 1'b1);
    idle(4);
    check_output("hold_data_out1", data_out1, 32'h0404_0404);
    check_output("hold_data_out2", data_out2, 32'h0404_0404);

    do_read(4'd7, 32'h0707_0707, 1'b1);
    do_write(4'd7, 32'h7777_7777, 4'b1111);
    idle(3);
    do_read(4'd7, 32'h7777_7777, 1'b1);
    idle(3);

    // The rd_lat=1 read completes before reset; the rd_lat=2 read is still in flight and must be dropped.
    do_read(4'd1, 32'h0101_0101, 1'b0);
    rst_n = 1'b0;
    tick();
    check_reset_outputs("midread_reset");
    rst_n = 1'b1;
    idle(4);
    rst_n = 1'b0;
    tick();
    check_reset_outputs("midinit_reset");
    rst_n = 1'b1;
    run_init();
    do_read(4'd0, 32'h0000_0000, 1'b1);
    do_read(4'd9, 32'h0000_0000, 1'b1);
    idle(4);

    check_output("q1_drained", q1.size(), 32'h0);
    check_output("q2_drained", q2.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
